// File: rtl/alu4b_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one external 4-bit ALU.
// Each operation goes IDLE (grant) -> EXEC (ALU settles) -> RESP (tagged response, backpressured).
module alu4b_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_in1,
   input  logic [3:0] req0_in2,
   input  logic [3:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_in1,
   input  logic [3:0] req1_in2,
   input  logic [3:0] req1_op,
   output logic [3:0] alu_in1,
   output logic [3:0] alu_in2,
   output logic [3:0] alu_op,
   input  logic [3:0] alu_out,
   input  logic       alu_negative,
   input  logic       alu_zero,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_data,
   output logic       rsp_negative,
   output logic       rsp_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state_reg, state_next;
   logic       last_grant_reg;
   logic       grant_idx;
   logic       accept;
   logic [1:0] valid_vec;
   logic [1:0] grant_vec;
   logic [1:0] ready_vec;
   logic [3:0] in1_vec [2];
   logic [3:0] in2_vec [2];
   logic [3:0] op_vec  [2];

   assign valid_vec  = {req1_valid, req0_valid};
   assign in1_vec[0] = req0_in1;
   assign in1_vec[1] = req1_in1;
   assign in2_vec[0] = req0_in2;
   assign in2_vec[1] = req1_in2;
   assign op_vec[0]  = req0_op;
   assign op_vec[1]  = req1_op;

   // Contention goes to the requester that did not win last; otherwise the lone valid one.
   assign grant_idx = (&valid_vec) ? ~last_grant_reg : valid_vec[1];
   assign grant_vec = {grant_idx, ~grant_idx};

   // rst_n gates ready so nothing is offered while reset is held.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         assign ready_vec[gi] = rst_n && (state_reg == IDLE) && valid_vec[gi] && grant_vec[gi];
      end
   endgenerate

   assign req0_ready = ready_vec[0];
   assign req1_ready = ready_vec[1];
   assign accept     = |ready_vec;
   assign rsp_valid  = (state_reg == RESP);

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         alu_in1        <= 4'd0;
         alu_in2        <= 4'd0;
         alu_op         <= 4'd0;
         rsp_id         <= 1'b0;
         rsp_data       <= 4'd0;
         rsp_negative   <= 1'b0;
         rsp_zero       <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            alu_in1        <= in1_vec[grant_idx];
            alu_in2        <= in2_vec[grant_idx];
            alu_op         <= op_vec[grant_idx];
            rsp_id         <= grant_idx;
            last_grant_reg <= grant_idx;
         end
         if (state_reg == EXEC) begin
            rsp_data     <= alu_out;
            rsp_negative <= alu_negative;
            rsp_zero     <= alu_zero;
         end
      end
   end

endmodule
